// File: rtl/fpu_pkg.sv
// Shared FPU constants for the sequential divider: per-width field sizes, canonical
// special values, FSM state encoding and flag bit positions.
package fpu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DIV   = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [63:0] NAN64   = 64'h7FF8_0000_0000_0000;
  localparam logic [63:0] INF64_P = 64'h7FF0_0000_0000_0000;
  localparam logic [63:0] INF64_N = 64'hFFF0_0000_0000_0000;
  localparam logic [63:0] NAN32   = 64'h0000_0000_7FC0_0000;
  localparam logic [63:0] INF32_P = 64'h0000_0000_7F80_0000;
  localparam logic [63:0] INF32_N = 64'h0000_0000_FF80_0000;
  localparam logic [63:0] ZERO    = 64'h0000_0000_0000_0000;

  localparam int FLG_INVALID   = 4;
  localparam int FLG_DIVZERO   = 3;
  localparam int FLG_OVERFLOW  = 2;
  localparam int FLG_UNDERFLOW = 1;
  localparam int FLG_INEXACT   = 0;

  function automatic int mant_size(input int bw);
    return (bw == 32) ? 23 : 52;
  endfunction

  function automatic int exp_size(input int bw);
    return (bw == 32) ? 8 : 11;
  endfunction

  function automatic int bias_of(input int bw);
    return (bw == 32) ? 127 : 1023;
  endfunction

  function automatic int qbits_of(input int bw);
    return mant_size(bw) + 3;
  endfunction

endpackage

// File: rtl/fp_div_mant_step.sv
// One restoring-division step: compare, conditionally subtract, shift left.
module fp_div_mant_step #(
  parameter int W = 54
) (
  input  logic [W-1:0] i_rem,
  input  logic [W-1:0] i_div,
  output logic [W-1:0] o_rem_next,
  output logic         o_q
);

  logic [W-1:0] w_diff;

  // Remainder stays below twice the divisor, so the shifted value always fits in W bits.
  always_comb begin
    w_diff = i_rem - i_div;
    o_q    = (i_rem >= i_div);
    if (o_q) begin
      o_rem_next = {w_diff[W-2:0], 1'b0};
    end else begin
      o_rem_next = {i_rem[W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/fp_div_seq.sv
// Multi-cycle IEEE-754 divider: special decode, radix-2 restoring divide, normalise, RNE round.
// Optional FP_DIV_FLAGS_EN adds a registered flags[4:0] output.
module fp_div_seq
  import fpu_pkg::*;
#(
  parameter int BUS_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BUS_WIDTH-1:0] in1,
  input  logic [BUS_WIDTH-1:0] in2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BUS_WIDTH-1:0] out,
  output logic                 busy
`ifdef FP_DIV_FLAGS_EN
  ,
  output logic [4:0]           flags
`endif
);

  localparam int M     = mant_size(BUS_WIDTH);
  localparam int E     = exp_size(BUS_WIDTH);
  localparam int BIAS  = bias_of(BUS_WIDTH);
  localparam int QBITS = qbits_of(BUS_WIDTH);
  localparam int RW    = M + 2;
  localparam int XW    = E + 2;
  localparam int CW    = $clog2(QBITS + 1);
  localparam logic [BUS_WIDTH-1:0] C_NAN   = BUS_WIDTH'((BUS_WIDTH == 32) ? NAN32 : NAN64);
  localparam logic [BUS_WIDTH-1:0] C_INF_P = BUS_WIDTH'((BUS_WIDTH == 32) ? INF32_P : INF64_P);
  localparam logic [BUS_WIDTH-1:0] C_INF_N = BUS_WIDTH'((BUS_WIDTH == 32) ? INF32_N : INF64_N);
  localparam logic [BUS_WIDTH-1:0] C_ZERO  = BUS_WIDTH'(ZERO);
  localparam logic signed [XW-1:0] EXP_MAX  = XW'(2 * BIAS + 1);
  localparam logic signed [XW-1:0] EXP_ZERO = XW'(0);

  state_t                 r_state;
  logic                   r_in_ready, r_out_valid, r_busy, r_phase, r_sign;
  logic [BUS_WIDTH-1:0]   r_out;
  logic [RW-1:0]          r_rem, r_div;
  logic [QBITS-1:0]       r_q;
  logic [CW-1:0]          r_cnt;
  logic signed [XW-1:0]   r_exp, r_nexp;
  logic [M-1:0]           r_nmant;
  logic                   r_guard, r_sticky;
  logic [4:0]             r_flags;

  logic                   w_s1, w_s2, w_sign;
  logic [E-1:0]           w_e1, w_e2;
  logic [M-1:0]           w_m1, w_m2;
  logic                   w_z1, w_z2, w_inf1, w_inf2, w_nan1, w_nan2;
  logic                   w_spec;
  logic [BUS_WIDTH-1:0]   w_spec_res;
  logic [4:0]             w_spec_flags;
  logic signed [XW-1:0]   w_exp_init;
  logic [RW-1:0]          w_rem_next;
  logic                   w_qbit, w_msb, w_inc, w_ovf, w_unf;
  logic [M-1:0]           w_nmant;
  logic                   w_nguard, w_nsticky;
  logic signed [XW-1:0]   w_nexp, w_rexp;
  logic [M:0]             w_sum;

  assign w_s1   = in1[BUS_WIDTH-1];
  assign w_s2   = in2[BUS_WIDTH-1];
  assign w_e1   = in1[BUS_WIDTH-2:M];
  assign w_e2   = in2[BUS_WIDTH-2:M];
  assign w_m1   = in1[M-1:0];
  assign w_m2   = in2[M-1:0];
  assign w_sign = w_s1 ^ w_s2;
  assign w_z1   = (w_e1 == '0);
  assign w_z2   = (w_e2 == '0);
  assign w_inf1 = (&w_e1) && (w_m1 == '0);
  assign w_inf2 = (&w_e2) && (w_m2 == '0);
  assign w_nan1 = (&w_e1) && (w_m1 != '0);
  assign w_nan2 = (&w_e2) && (w_m2 != '0);
  assign w_exp_init = $signed({2'b00, w_e1} - {2'b00, w_e2} + XW'(BIAS));

  // Special-operand classification, highest priority first; subnormals count as zero.
  always_comb begin
    w_spec       = 1'b1;
    w_spec_res   = C_NAN;
    w_spec_flags = 5'b00000;
    if (w_nan1 || w_nan2) begin
      w_spec_res = C_NAN;
    end else if ((w_z1 && w_z2) || (w_inf1 && w_inf2)) begin
      w_spec_res                = C_NAN;
      w_spec_flags[FLG_INVALID] = 1'b1;
    end else if (w_inf1 || w_z2) begin
      w_spec_res                = w_sign ? C_INF_N : C_INF_P;
      w_spec_flags[FLG_DIVZERO] = !w_inf1;
    end else if (w_z1 || w_inf2) begin
      w_spec_res = {w_sign, C_ZERO[BUS_WIDTH-2:0]};
    end else begin
      w_spec = 1'b0;
    end
  end

  fp_div_mant_step #(.W(RW)) u_step (
    .i_rem      (r_rem),
    .i_div      (r_div),
    .o_rem_next (w_rem_next),
    .o_q        (w_qbit)
  );

  // Quotient lies in [0.5,2): a clear MSB means one extra left shift and exponent decrement.
  assign w_msb     = r_q[QBITS-1];
  assign w_nmant   = w_msb ? r_q[M+1:2] : r_q[M:1];
  assign w_nguard  = w_msb ? r_q[1] : r_q[0];
  assign w_nsticky = (w_msb & r_q[0]) | (|r_rem);
  assign w_nexp    = r_exp - $signed({{(XW-1){1'b0}}, ~w_msb});

  assign w_inc  = r_guard & (r_sticky | r_nmant[0]);
  assign w_sum  = {1'b0, r_nmant} + {{M{1'b0}}, w_inc};
  assign w_rexp = r_nexp + $signed({{(XW-1){1'b0}}, w_sum[M]});
  assign w_ovf  = (w_rexp >= EXP_MAX);
  assign w_unf  = (w_rexp <= EXP_ZERO);

  // Control FSM plus datapath registers; flush returns to IDLE and discards the op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_out       <= '0;
      r_phase     <= 1'b0;
      r_sign      <= 1'b0;
      r_rem       <= '0;
      r_div       <= '0;
      r_q         <= '0;
      r_cnt       <= '0;
      r_exp       <= '0;
      r_nexp      <= '0;
      r_nmant     <= '0;
      r_guard     <= 1'b0;
      r_sticky    <= 1'b0;
      r_flags     <= 5'b00000;
    end else if (flush) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_sign     <= w_sign;
            r_exp      <= w_exp_init;
            if (w_spec) begin
              r_out       <= w_spec_res;
              r_flags     <= w_spec_flags;
              r_out_valid <= 1'b1;
              r_state     <= DONE;
            end else begin
              r_rem   <= {1'b0, 1'b1, w_m1};
              r_div   <= {1'b0, 1'b1, w_m2};
              r_q     <= '0;
              r_cnt   <= '0;
              r_state <= DIV;
            end
          end
        end
        DIV: begin
          r_rem <= w_rem_next;
          r_q   <= {r_q[QBITS-2:0], w_qbit};
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(QBITS - 1)) begin
            r_phase <= 1'b0;
            r_state <= ROUND;
          end
        end
        ROUND: begin
          if (!r_phase) begin
            r_nmant  <= w_nmant;
            r_guard  <= w_nguard;
            r_sticky <= w_nsticky;
            r_nexp   <= w_nexp;
            r_phase  <= 1'b1;
          end else begin
            if (w_ovf) begin
              r_out <= r_sign ? C_INF_N : C_INF_P;
            end else if (w_unf) begin
              r_out <= {r_sign, C_ZERO[BUS_WIDTH-2:0]};
            end else begin
              r_out <= {r_sign, w_rexp[E-1:0], w_sum[M-1:0]};
            end
            r_flags     <= {1'b0, 1'b0, w_ovf, w_unf, r_guard | r_sticky | w_ovf | w_unf};
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out       = r_out;
  assign busy      = r_busy;
`ifdef FP_DIV_FLAGS_EN
  assign flags     = r_flags;
`else
  logic w_flags_unused;
  assign w_flags_unused = ^r_flags;
`endif

endmodule
